des3_wb_master: RTL and testbench

- Wishbone initiator that drives a memory-mapped DES3 slave through one complete operation.
- Accepts a 64-bit block, three 64-bit keys and a decrypt flag on a valid/ready command port.
- Writes the slave register map, sets start, polls ct_valid, reads the 64-bit result, clears start, and returns the result and a status code on a valid/ready response port.
- Sits between a local controller or DMA sequencer and the DES3 slave on the shared Wishbone fabric.

---
 rtl/des3_wb_master.sv | 206 ++++++++++++++++++++
 tb/tb_des3_wb_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des3_wb_master.sv
// Wishbone initiator that runs one DES3 operation on a memory-mapped slave:
// it loads the key/block registers, starts the core, polls ct_valid, reads the result back and clears start.
module des3_wb_master #(
  parameter int unsigned aw          = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned POLL_MAX    = 1023
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_decrypt_i,
  input  logic [63:0]   cmd_data_i,
  input  logic [63:0]   cmd_key1_i,
  input  logic [63:0]   cmd_key2_i,
  input  logic [63:0]   cmd_key3_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [63:0]   rsp_data_o,
  output logic [1:0]    rsp_err_o,
  output logic          busy_o,
  output logic [aw-1:0] wb_adr_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic [31:0]   wb_dat_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);
  typedef enum logic [2:0] {IDLE, WR_SEQ, POLL, RD_HI, RD_LO, CLR, RESP} state_t;

  localparam logic [16:0] ACK_LIM  = 17'(ACK_TIMEOUT);
  localparam logic [16:0] POLL_LIM = 17'(POLL_MAX);
  localparam logic [1:0]  E_OK     = 2'b00;
  localparam logic [1:0]  E_BUS    = 2'b01;
  localparam logic [1:0]  E_ACK    = 2'b10;
  localparam logic [1:0]  E_POLL   = 2'b11;

  state_t        state_q;
  logic          cmd_ready_q, busy_q, stb_q, we_q, rsp_valid_q, dec_q;
  logic [aw-1:0] adr_q;
  logic [31:0]   dat_q;
  logic [63:0]   data_q, key1_q, key2_q, key3_q, result_q, rsp_data_q;
  logic [1:0]    err_q;
  logic [3:0]    wr_idx_q;
  logic [15:0]   ack_cnt_q, poll_cnt_q;

  logic [3:0]    idx_d;
  logic          we_d;
  logic [31:0]   dat_d;
  logic [aw-1:0] adr_d;

  // Address/data of the transfer the current state issues next.
  always_comb begin
    idx_d = 4'd0;
    we_d  = 1'b0;
    dat_d = 32'd0;
    case (state_q)
      WR_SEQ: begin
        we_d  = 1'b1;
        idx_d = (wr_idx_q == 4'd10) ? 4'd0 : wr_idx_q;
        case (wr_idx_q)
          4'd1:    dat_d = {31'd0, dec_q};
          4'd2:    dat_d = data_q[31:0];
          4'd3:    dat_d = data_q[63:32];
          4'd4:    dat_d = key3_q[31:0];
          4'd5:    dat_d = key3_q[63:32];
          4'd6:    dat_d = key2_q[31:0];
          4'd7:    dat_d = key2_q[63:32];
          4'd8:    dat_d = key1_q[31:0];
          4'd9:    dat_d = key1_q[63:32];
          4'd10:   dat_d = 32'd1;
          default: dat_d = 32'd0;
        endcase
      end
      POLL:    idx_d = 4'd10;
      RD_HI:   idx_d = 4'd11;
      RD_LO:   idx_d = 4'd12;
      CLR:     we_d  = 1'b1;
      default: idx_d = 4'd0;
    endcase
    adr_d = aw'(BASE_ADDR) + aw'({idx_d, 2'b00});
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 64'd0;
      err_q       <= E_OK;
      dec_q       <= 1'b0;
      data_q      <= 64'd0;
      key1_q      <= 64'd0;
      key2_q      <= 64'd0;
      key3_q      <= 64'd0;
      result_q    <= 64'd0;
      wr_idx_q    <= 4'd0;
      ack_cnt_q   <= 16'd0;
      poll_cnt_q  <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            dec_q       <= cmd_decrypt_i;
            data_q      <= cmd_data_i;
            key1_q      <= cmd_key1_i;
            key2_q      <= cmd_key2_i;
            key3_q      <= cmd_key3_i;
            result_q    <= 64'd0;
            err_q       <= E_OK;
            wr_idx_q    <= 4'd0;
            poll_cnt_q  <= 16'd0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= WR_SEQ;
          end
        end
        WR_SEQ, POLL, RD_HI, RD_LO, CLR: begin
          if (!stb_q) begin
            stb_q     <= 1'b1;
            adr_q     <= adr_d;
            we_q      <= we_d;
            dat_q     <= dat_d;
            ack_cnt_q <= 16'd0;
          end else if (wb_err_i) begin
            stb_q      <= 1'b0;
            err_q      <= E_BUS;
            rsp_data_q <= 64'd0;
            state_q    <= RESP;
          end else if (wb_ack_i) begin
            stb_q <= 1'b0;
            case (state_q)
              WR_SEQ: begin
                if (wr_idx_q == 4'd10) state_q <= POLL;
                else wr_idx_q <= wr_idx_q + 4'd1;
              end
              POLL: begin
                if (wb_dat_i[0]) begin
                  state_q <= RD_HI;
                end else if ({1'b0, poll_cnt_q} + 17'd1 == POLL_LIM) begin
                  err_q   <= E_POLL;
                  state_q <= CLR;
                end else begin
                  poll_cnt_q <= poll_cnt_q + 16'd1;
                end
              end
              RD_HI: begin
                result_q[63:32] <= wb_dat_i;
                state_q         <= RD_LO;
              end
              RD_LO: begin
                result_q[31:0] <= wb_dat_i;
                state_q        <= CLR;
              end
              default: begin
                rsp_data_q <= (err_q == E_OK) ? result_q : 64'd0;
                state_q    <= RESP;
              end
            endcase
          end else if ({1'b0, ack_cnt_q} + 17'd1 == ACK_LIM) begin
            stb_q      <= 1'b0;
            err_q      <= E_ACK;
            rsp_data_q <= 64'd0;
            state_q    <= RESP;
          end else begin
            ack_cnt_q <= ack_cnt_q + 16'd1;
          end
        end
        RESP: begin
          // Valid rises one cycle after entry; the consume edge returns to IDLE.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = err_q;
  assign wb_cyc_o    = stb_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = 4'hF;

endmodule

// File: tb/tb_des3_wb_master.sv
// Bench for des3_wb_master: a Wishbone DES3 slave model with configurable waits, errors and
// ct_valid delay, and a transaction-level model of the expected register traffic and response.
module tb_des3_wb_master;
  localparam logic [31:0] BASE    = 32'h0000_4000;
  localparam int          ACK_TO  = 8;
  localparam int          PMAX    = 4;
  localparam logic [63:0] KAT_KEY = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_PT  = 64'h4E6F772069732074;
  localparam logic [63:0] KAT_CT  = 64'h3FA40E8A984D4815;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_dec, rsp_valid, rsp_ready, busy;
  logic [63:0] cmd_data, cmd_k1, cmd_k2, cmd_k3, rsp_data;
  logic [1:0]  rsp_err;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [3:0]  wb_sel;

  des3_wb_master #(.aw(32), .BASE_ADDR(BASE), .ACK_TIMEOUT(ACK_TO), .POLL_MAX(PMAX)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_decrypt_i(cmd_dec),
    .cmd_data_i(cmd_data), .cmd_key1_i(cmd_k1), .cmd_key2_i(cmd_k2), .cmd_key3_i(cmd_k3),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .busy_o(busy), .wb_adr_o(wb_adr), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave core: published single-key DES3 vectors, otherwise a keyed mix of the block.
  function automatic logic [63:0] cipher(input logic dec, input logic [63:0] d, k1, k2, k3);
    if (k1 == KAT_KEY && k2 == KAT_KEY && k3 == KAT_KEY) begin
      if (!dec && d == KAT_PT) return KAT_CT;
      if (dec && d == KAT_CT) return KAT_PT;
    end
    return {d[31:0], d[63:32]} ^ k1 ^ {k2[62:0], k2[63]} ^ ~k3 ^ {64{dec}};
  endfunction

  typedef logic [36:0] xfer_t;  // {we, word index, write data}
  xfer_t       trace[$];
  xfer_t       exp_q[$];
  logic [31:0] regs [0:15];
  logic [63:0] ct;
  int          nx = 0, wcnt = 0, polls_seen = 0;
  int          wait_n = 0, pbv = 0, err_at = -1;
  logic        never_ack = 1'b0;
  logic [31:0] off, rdat;
  logic [3:0]  s_idx;
  logic        s_rdy;

  assign off    = wb_adr - BASE;
  assign s_idx  = (off[1:0] == 2'b00 && off < 32'd52) ? off[5:2] : 4'hF;
  assign s_rdy  = wb_stb && !never_ack && (wcnt >= wait_n);
  assign wb_ack = s_rdy;
  assign wb_err = s_rdy && (nx == err_at);
  assign wb_dat_i = rdat;

  always_comb begin
    rdat = 32'hDEAD_BEEF;
    if (s_idx == 4'd10)      rdat = {31'd0, polls_seen >= pbv};
    else if (s_idx == 4'd11) rdat = ct[63:32];
    else if (s_idx == 4'd12) rdat = ct[31:0];
    else if (s_idx < 4'd10)  rdat = regs[s_idx];
  end

  always @(posedge clk) begin
    if (wb_stb && s_rdy) begin
      trace.push_back({wb_we, s_idx, wb_we ? wb_dat_o : 32'h0});
      nx   <= nx + 1;
      wcnt <= 0;
      if (wb_we && !wb_err) begin
        regs[s_idx] <= wb_dat_o;
        if (s_idx == 4'd0 && wb_dat_o[0]) begin
          ct <= cipher(regs[1][0], {regs[3], regs[2]}, {regs[9], regs[8]},
                       {regs[7], regs[6]}, {regs[5], regs[4]});
          polls_seen <= 0;
        end
      end
      if (!wb_we && s_idx == 4'd10) polls_seen <= polls_seen + 1;
    end else if (wb_stb) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  // Bus protocol watcher: cyc==stb, sel, stable request, one idle cycle between transfers.
  int          stb_cyc = 0, proto_bad = 0, gap = 0;
  logic        had_xfer = 1'b0, prev_stb = 1'b0;
  logic [64:0] prev_bus = '0;
  always @(negedge clk) begin
    if (wb_cyc !== wb_stb) proto_bad++;
    if (wb_stb === 1'b1) begin
      stb_cyc++;
      if (wb_sel !== 4'hF) proto_bad++;
      if (prev_stb && {wb_we, wb_adr, wb_dat_o} !== prev_bus) proto_bad++;
      if (!prev_stb && had_xfer && gap != 1) proto_bad++;
      had_xfer = 1'b1;
      gap = 0;
    end else if (busy === 1'b1 && had_xfer) begin
      gap++;
    end
    if (busy === 1'b0) begin
      had_xfer = 1'b0;
      gap = 0;
    end
    prev_stb = (wb_stb === 1'b1);
    prev_bus = {wb_we, wb_adr, wb_dat_o};
  end

  function automatic xfer_t wr(input logic [3:0] idx, input logic [31:0] v);
    return {1'b1, idx, v};
  endfunction
  function automatic xfer_t rd(input logic [3:0] idx);
    return {1'b0, idx, 32'h0};
  endfunction

  task automatic model_seq(input logic dec, input logic [63:0] d, k1, k2, k3,
                           input int n_polls, input bit got_ct, input int keep);
    exp_q.delete();
    exp_q.push_back(wr(4'd0, 32'd0));
    exp_q.push_back(wr(4'd1, {31'd0, dec}));
    exp_q.push_back(wr(4'd2, d[31:0]));
    exp_q.push_back(wr(4'd3, d[63:32]));
    exp_q.push_back(wr(4'd4, k3[31:0]));
    exp_q.push_back(wr(4'd5, k3[63:32]));
    exp_q.push_back(wr(4'd6, k2[31:0]));
    exp_q.push_back(wr(4'd7, k2[63:32]));
    exp_q.push_back(wr(4'd8, k1[31:0]));
    exp_q.push_back(wr(4'd9, k1[63:32]));
    exp_q.push_back(wr(4'd0, 32'd1));
    repeat (n_polls) exp_q.push_back(rd(4'd10));
    if (got_ct) begin
      exp_q.push_back(rd(4'd11));
      exp_q.push_back(rd(4'd12));
    end
    exp_q.push_back(wr(4'd0, 32'd0));
    while (exp_q.size() > keep) void'(exp_q.pop_back());
  endtask

  task automatic do_cmd(input string name, input logic dec, input logic [63:0] d, k1, k2, k3,
                        input int hold, output logic [63:0] r_dat, output logic [1:0] r_err,
                        output int lat);
    int   g;
    logic stable;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dec = dec; cmd_data = d; cmd_k1 = k1; cmd_k2 = k2; cmd_k3 = k3;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq({name, "/cmd_ready"}, cmd_ready, 1);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_dec  = 1'($urandom);
    cmd_data = {$urandom, $urandom};
    cmd_k1   = {$urandom, $urandom};
    cmd_k2   = {$urandom, $urandom};
    cmd_k3   = {$urandom, $urandom};
    while (rsp_valid !== 1'b1 && lat < 3000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq({name, "/rsp_valid"}, rsp_valid, 1);
    r_dat  = rsp_data;
    r_err  = rsp_err;
    stable = 1'b1;
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      if (!(rsp_valid === 1'b1 && rsp_data === r_dat && rsp_err === r_err && cmd_ready === 1'b0))
        stable = 1'b0;
    end
    check_eq({name, "/rsp_hold"}, stable, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({name, "/release"}, {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  // mode: 0 normal, 1 bus error on 4th transfer, 2 ack timeout, 3 poll timeout
  task automatic run_case(input string name, input logic dec, input logic [63:0] d, k1, k2, k3,
                          input int w, input int pv, input int hold, input int mode);
    logic [63:0] r_dat, exp_dat;
    logic [1:0]  r_err, exp_err;
    int          lat, base, stb0;
    wait_n    = w;
    pbv       = pv;
    never_ack = (mode == 2);
    base      = nx;
    stb0      = stb_cyc;
    err_at    = (mode == 1) ? nx + 3 : -1;
    do_cmd(name, dec, d, k1, k2, k3, hold, r_dat, r_err, lat);
    exp_dat = 64'd0;
    case (mode)
      1: begin model_seq(dec, d, k1, k2, k3, 0, 1'b0, 4); exp_err = 2'b01; end
      2: begin model_seq(dec, d, k1, k2, k3, 0, 1'b0, 0); exp_err = 2'b10; end
      3: begin model_seq(dec, d, k1, k2, k3, PMAX, 1'b0, 100); exp_err = 2'b11; end
      default: begin
        model_seq(dec, d, k1, k2, k3, pv + 1, 1'b1, 100);
        exp_err = 2'b00;
        exp_dat = cipher(dec, d, k1, k2, k3);
      end
    endcase
    check_eq({name, "/rsp_err"}, r_err, exp_err);
    check_eq({name, "/rsp_data"}, r_dat, exp_dat);
    if (mode == 0) check_eq({name, "/latency"}, lat, exp_q.size() * (2 + w) + 1);
    if (mode == 2) check_eq({name, "/stb_cycles"}, stb_cyc - stb0, ACK_TO);
    check_eq({name, "/xfer_count"}, nx - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < nx; i++)
      check_eq($sformatf("%s/xfer%0d", name, i), trace[base + i], exp_q[i]);
    never_ack = 1'b0;
    err_at    = -1;
  endtask

  initial begin
    logic [63:0] d, k1, k2, k3;
    int          g;
    cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_dec = 1'b0;
    cmd_data = 64'd0; cmd_k1 = 64'd0; cmd_k2 = 64'd0; cmd_k3 = 64'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset/cmd_ready", cmd_ready, 1);
    check_eq("reset/ctl", {busy, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we}, 0);
    check_eq("reset/rsp_data", rsp_data, 0);
    check_eq("reset/bus", {wb_adr, wb_dat_o}, 0);
    rst = 1'b0;

    run_case("kat_enc", 1'b0, KAT_PT, KAT_KEY, KAT_KEY, KAT_KEY, 0, 0, 0, 0);
    run_case("kat_dec", 1'b1, KAT_CT, KAT_KEY, KAT_KEY, KAT_KEY, 0, 0, 10, 0);
    run_case("kat_wait3", 1'b0, KAT_PT, KAT_KEY, KAT_KEY, KAT_KEY, 3, 0, 2, 0);
    run_case("bus_err", 1'b0, KAT_PT, KAT_KEY, KAT_KEY, KAT_KEY, 0, 0, 3, 1);
    run_case("ack_timeout", 1'b1, KAT_CT, KAT_KEY, KAT_KEY, KAT_KEY, 0, 0, 1, 2);
    run_case("poll_timeout", 1'b0, KAT_PT, KAT_KEY, KAT_KEY, KAT_KEY, 1, 1000, 0, 3);

    // Reset while the master is polling a slave that never completes.
    pbv = 1000;
    wait_n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dec = 1'b0; cmd_data = KAT_PT;
    cmd_k1 = KAT_KEY; cmd_k2 = KAT_KEY; cmd_k3 = KAT_KEY;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    g = 0;
    while (!(wb_stb === 1'b1 && wb_we === 1'b0 && s_idx == 4'd10) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check_eq("midrst/in_poll", {wb_stb, wb_we, s_idx}, {1'b1, 1'b0, 4'd10});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst/bus", {wb_cyc, wb_stb}, 2'b00);
    check_eq("midrst/rsp", {rsp_valid, cmd_ready, busy}, 3'b010);
    rst = 1'b0;
    run_case("after_rst", 1'b0, KAT_PT, KAT_KEY, KAT_KEY, KAT_KEY, 0, 0, 1, 0);

    for (int i = 0; i < 16; i++) begin
      d  = {$urandom, $urandom};
      k1 = {$urandom, $urandom};
      k2 = {$urandom, $urandom};
      k3 = {$urandom, $urandom};
      run_case($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), d, k1, k2, k3,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 4)), 0);
    end

    check_eq("protocol", proto_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
